// File: rtl/display_scanner_pkg.sv
// Shared constants for the seven-segment display blocks: special digit codes
// and active-low glyph patterns in {g,f,e,d,c,b,a} order.
package display_scanner_pkg;

    // Digit codes beyond the hex range
    localparam logic [4:0] CODE_BLANK = 5'd16;
    localparam logic [4:0] CODE_MINUS = 5'd17;
    localparam logic [4:0] CODE_E     = 5'd18;

    // Active-low glyphs, bit 6 = g ... bit 0 = a
    localparam logic [6:0] GLYPH_0     = 7'b1000000;
    localparam logic [6:0] GLYPH_1     = 7'b1111001;
    localparam logic [6:0] GLYPH_2     = 7'b0100100;
    localparam logic [6:0] GLYPH_3     = 7'b0110000;
    localparam logic [6:0] GLYPH_4     = 7'b0011001;
    localparam logic [6:0] GLYPH_5     = 7'b0010010;
    localparam logic [6:0] GLYPH_6     = 7'b0000010;
    localparam logic [6:0] GLYPH_7     = 7'b1111000;
    localparam logic [6:0] GLYPH_8     = 7'b0000000;
    localparam logic [6:0] GLYPH_9     = 7'b0010000;
    localparam logic [6:0] GLYPH_A     = 7'b0001000;
    localparam logic [6:0] GLYPH_B     = 7'b0000011;
    localparam logic [6:0] GLYPH_C     = 7'b1000110;
    localparam logic [6:0] GLYPH_D     = 7'b0100001;
    localparam logic [6:0] GLYPH_E     = 7'b0000110;
    localparam logic [6:0] GLYPH_F     = 7'b0001110;
    localparam logic [6:0] GLYPH_BLANK = 7'b1111111;
    localparam logic [6:0] GLYPH_MINUS = 7'b0111111;

    // Active-low one-hot anode pattern for a digit index
    function automatic logic [3:0] digit_anode_n(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational 5-bit digit code to active-low seven-segment pattern.
// Codes 0-15 give hex glyphs; 17 is '-', 18 is 'E'; everything else is blank.
module seg7_decode
    import display_scanner_pkg::*;
(
    input  logic [4:0] code,
    output logic [6:0] seg_n
);

    // Code-to-glyph lookup
    always_comb begin
        seg_n = GLYPH_BLANK;
        case (code)
            5'd0:       seg_n = GLYPH_0;
            5'd1:       seg_n = GLYPH_1;
            5'd2:       seg_n = GLYPH_2;
            5'd3:       seg_n = GLYPH_3;
            5'd4:       seg_n = GLYPH_4;
            5'd5:       seg_n = GLYPH_5;
            5'd6:       seg_n = GLYPH_6;
            5'd7:       seg_n = GLYPH_7;
            5'd8:       seg_n = GLYPH_8;
            5'd9:       seg_n = GLYPH_9;
            5'd10:      seg_n = GLYPH_A;
            5'd11:      seg_n = GLYPH_B;
            5'd12:      seg_n = GLYPH_C;
            5'd13:      seg_n = GLYPH_D;
            5'd14:      seg_n = GLYPH_E;
            5'd15:      seg_n = GLYPH_F;
            CODE_MINUS: seg_n = GLYPH_MINUS;
            CODE_E:     seg_n = GLYPH_E;
            default:    seg_n = GLYPH_BLANK;
        endcase
    end

endmodule

// File: rtl/display_scanner.sv
// Time-multiplexed scanner for a 4-digit common-anode seven-segment display.
// Digit codes are snapshotted once per frame (as the digit index wraps to 0),
// so a frame never mixes old and new data. Every output is registered and
// lags the internal slot counter, digit index, shadows and en by one clock.
module display_scanner
    import display_scanner_pkg::*;
#(
    parameter int PRESCALE     = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] a1,
    input  logic [4:0] a2,
    input  logic [4:0] a3,
    input  logic [4:0] a4,
    input  logic [3:0] dp,
    input  logic       en,
    output logic [6:0] seg_n,
    output logic       dp_n,
    output logic [3:0] an_n,
    output logic       frame_tick
);

    localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);

    logic [CNT_W-1:0] cnt;
    logic [1:0]       idx;
    logic [4:0]       sh1, sh2, sh3, sh4;
    logic [3:0]       shdp;
    logic             frame_start;
    logic             slot_end;
    logic             frame_end;
    logic [4:0]       sel_code;
    logic [6:0]       dec_seg;

    assign slot_end  = (cnt == CNT_LAST);
    assign frame_end = slot_end && (idx == 2'd3);

    // Slot prescaler and digit index; idx steps when the slot counter wraps
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= 2'd0;
        end else if (slot_end) begin
            cnt <= '0;
            idx <= idx + 2'd1;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Frame snapshot of the digit codes, taken on the same edge idx wraps 3->0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh1  <= CODE_BLANK;
            sh2  <= CODE_BLANK;
            sh3  <= CODE_BLANK;
            sh4  <= CODE_BLANK;
            shdp <= 4'b0000;
        end else if (frame_end) begin
            sh1  <= a1;
            sh2  <= a2;
            sh3  <= a3;
            sh4  <= a4;
            shdp <= dp;
        end
    end

    // Marks the first internal cycle of slot 0; becomes frame_tick one clock
    // later so the pulse lines up with the new data on seg_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_start <= 1'b0;
        end else begin
            frame_start <= frame_end;
        end
    end

    // Select the shadow code for the digit currently being scanned
    always_comb begin
        sel_code = sh1;
        case (idx)
            2'd0: sel_code = sh1;
            2'd1: sel_code = sh2;
            2'd2: sel_code = sh3;
            2'd3: sel_code = sh4;
            default: sel_code = sh1;
        endcase
    end

    seg7_decode u_decode (
        .code  (sel_code),
        .seg_n (dec_seg)
    );

    // Output registers; anodes stay dark for the first BLANK_CYCLES of each
    // slot so the segment lines settle before the next digit lights.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_n      <= GLYPH_BLANK;
            dp_n       <= 1'b1;
            an_n       <= 4'b1111;
            frame_tick <= 1'b0;
        end else begin
            seg_n      <= dec_seg;
            dp_n       <= ~shdp[idx];
            an_n       <= (en && (cnt >= CNT_BLANK)) ? digit_anode_n(idx) : 4'b1111;
            frame_tick <= frame_start;
        end
    end

endmodule

// File: tb/tb_display_scanner.sv
// Self-checking bench for display_scanner with PRESCALE = 8, BLANK_CYCLES = 2.
// A frame-level reference model predicts every output each clock from the
// elapsed clock count since reset and the inputs seen at each frame boundary.
module tb_display_scanner;

    localparam int P  = 8;
    localparam int B  = 2;
    localparam int FR = 4 * P;

    localparam logic [6:0] HEX [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [4:0] a1 = '0, a2 = '0, a3 = '0, a4 = '0;
    logic [3:0] dp = '0;
    logic       en = 1'b1;
    logic [6:0] seg_n;
    logic       dp_n;
    logic [3:0] an_n;
    logic       frame_tick;

    int checks = 0;
    int errors = 0;

    display_scanner #(.PRESCALE(P), .BLANK_CYCLES(B)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .a1         (a1),
        .a2         (a2),
        .a3         (a3),
        .a4         (a4),
        .dp         (dp),
        .en         (en),
        .seg_n      (seg_n),
        .dp_n       (dp_n),
        .an_n       (an_n),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    // Reference model ------------------------------------------------------
    int         m_step;
    int         m_cnt;
    int         m_idx;
    logic       m_pend;
    logic [4:0] m_code [4];
    logic [3:0] m_dp;
    logic [6:0] exp_seg;
    logic       exp_dp;
    logic [3:0] exp_an;
    logic       exp_tick;

    function automatic logic [6:0] ref_glyph(input logic [4:0] c);
        if (c < 5'd16) return HEX[c[3:0]];
        if (c == 5'd17) return 7'h3F;
        if (c == 5'd18) return 7'h06;
        return 7'h7F;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_step = 0;
            m_pend = 1'b0;
            for (int k = 0; k < 4; k++) m_code[k] = 5'd16;
            m_dp     = 4'b0000;
            exp_seg  = 7'h7F;
            exp_dp   = 1'b1;
            exp_an   = 4'hF;
            exp_tick = 1'b0;
        end else begin
            m_cnt    = m_step % P;
            m_idx    = (m_step / P) % 4;
            exp_an   = (en && m_cnt >= B) ? ~(4'b0001 << m_idx) : 4'hF;
            exp_seg  = ref_glyph(m_code[m_idx]);
            exp_dp   = ~m_dp[m_idx];
            exp_tick = m_pend;
            m_pend   = ((m_step % FR) == FR - 1);
            if (m_pend) begin
                m_code[0] = a1;
                m_code[1] = a2;
                m_code[2] = a3;
                m_code[3] = a4;
                m_dp      = dp;
            end
            m_step++;
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Tests ----------------------------------------------------------------
    task automatic test_reset();
        int first;
        first = -1;
        a1 = 5'd8; a2 = 5'd8; a3 = 5'd8; a4 = 5'd8; dp = 4'hF; en = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({seg_n, dp_n, an_n, frame_tick} !== {7'h7F, 1'b1, 4'hF, 1'b0}) begin
            errors++;
            $display("FAIL reset_values: got seg=%b dp=%b an=%b tick=%b want 1111111 1 1111 0", seg_n, dp_n, an_n, frame_tick);
        end
        next_cycle();
        next_cycle();
        checks++;
        if ({seg_n, dp_n, an_n, frame_tick} !== {7'h7F, 1'b1, 4'hF, 1'b0}) begin
            errors++;
            $display("FAIL reset_held: got seg=%b dp=%b an=%b tick=%b want 1111111 1 1111 0", seg_n, dp_n, an_n, frame_tick);
        end
        @(negedge clk) rst_n = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            next_cycle();
            checks++;
            if ({seg_n, dp_n, an_n, frame_tick} !== {exp_seg, exp_dp, exp_an, exp_tick}) begin
                errors++;
                $display("FAIL reset_model n=%0d: got seg=%b dp=%b an=%b tick=%b want seg=%b dp=%b an=%b tick=%b", n, seg_n, dp_n, an_n, frame_tick, exp_seg, exp_dp, exp_an, exp_tick);
            end
            if (frame_tick && first < 0) first = n;
            if (n <= FR) begin
                checks++;
                if (seg_n !== 7'h7F) begin
                    errors++;
                    $display("FAIL reset_frame0_blank n=%0d: got seg=%b want 1111111", n, seg_n);
                end
            end
        end
        checks++;
        if (first != FR + 1) begin
            errors++;
            $display("FAIL reset_first_tick: got edge %0d want edge %0d", first, FR + 1);
        end
    endtask

    task automatic test_digits();
        int ticks;
        int guard;
        ticks = 0;
        guard = 0;
        @(negedge clk);
        a1 = 5'd4; a2 = 5'd3; a3 = 5'd2; a4 = 5'd1; dp = 4'b0001; en = 1'b1;
        while (ticks < 2 && guard < 3 * FR) begin
            next_cycle();
            guard++;
            if (frame_tick) ticks++;
        end
        checks++;
        if (ticks != 2) begin
            errors++;
            $display("FAIL digits_tick_timeout: got %0d ticks want 2", ticks);
        end
        for (int j = 0; j < FR + 8; j++) begin
            if (j > 0) next_cycle();
            checks++;
            if ({seg_n, dp_n, an_n, frame_tick} !== {exp_seg, exp_dp, exp_an, exp_tick}) begin
                errors++;
                $display("FAIL digits_model j=%0d: got seg=%b dp=%b an=%b tick=%b want seg=%b dp=%b an=%b tick=%b", j, seg_n, dp_n, an_n, frame_tick, exp_seg, exp_dp, exp_an, exp_tick);
            end
            if (j < P) begin
                checks++;
                if ({an_n, seg_n, dp_n} !== {((j < B) ? 4'hF : 4'hE), 7'h19, 1'b0}) begin
                    errors++;
                    $display("FAIL digits_slot0 j=%0d: got an=%b seg=%b dp=%b", j, an_n, seg_n, dp_n);
                end
            end
            if (j >= 3 * P + B && j < FR) begin
                checks++;
                if ({an_n, seg_n, dp_n} !== {4'h7, 7'h79, 1'b1}) begin
                    errors++;
                    $display("FAIL digits_slot3 j=%0d: got an=%b seg=%b dp=%b want 0111 1111001 1", j, an_n, seg_n, dp_n);
                end
            end
            if (j >= 2 * P && j < FR) begin
                checks++;
                if (seg_n !== ((j < 3 * P) ? 7'h24 : 7'h79)) begin
                    errors++;
                    $display("FAIL digits_no_midframe_update j=%0d: got seg=%b", j, seg_n);
                end
            end
            if (j >= FR) begin
                checks++;
                if ({an_n, seg_n, frame_tick} !== {((j - FR < B) ? 4'hF : 4'hE), 7'h00, (j == FR)}) begin
                    errors++;
                    $display("FAIL digits_new_frame j=%0d: got an=%b seg=%b tick=%b want seg 0000000", j, an_n, seg_n, frame_tick);
                end
            end
            if (j == 2 * P + 3) begin
                @(negedge clk);
                a1 = 5'd8;
            end
        end
    endtask

    task automatic test_codes();
        int ticks;
        int guard;
        logic [6:0] want [4];
        want = '{7'h7F, 7'h3F, 7'h06, 7'h7F};
        ticks = 0;
        guard = 0;
        @(negedge clk);
        a1 = 5'd16; a2 = 5'd17; a3 = 5'd18; a4 = 5'd31; dp = 4'b1010;
        while (ticks < 2 && guard < 3 * FR) begin
            next_cycle();
            guard++;
            if (frame_tick) ticks++;
        end
        checks++;
        if (ticks != 2) begin
            errors++;
            $display("FAIL codes_tick_timeout: got %0d ticks want 2", ticks);
        end
        for (int j = 0; j < FR; j++) begin
            if (j > 0) next_cycle();
            checks++;
            if ({seg_n, dp_n, an_n, frame_tick} !== {exp_seg, exp_dp, exp_an, exp_tick}) begin
                errors++;
                $display("FAIL codes_model j=%0d: got seg=%b dp=%b an=%b tick=%b want seg=%b dp=%b an=%b tick=%b", j, seg_n, dp_n, an_n, frame_tick, exp_seg, exp_dp, exp_an, exp_tick);
            end
            checks++;
            if ({seg_n, dp_n} !== {want[j / P], !dp[j / P]}) begin
                errors++;
                $display("FAIL codes_glyph j=%0d: got seg=%b dp=%b want seg=%b", j, seg_n, dp_n, want[j / P]);
            end
        end
    endtask

    task automatic test_enable();
        int ticks;
        int guard;
        ticks = 0;
        guard = 0;
        @(negedge clk);
        a1 = 5'd5; a2 = 5'd6; a3 = 5'd7; a4 = 5'd9; dp = 4'b0000; en = 1'b1;
        while (ticks < 2 && guard < 3 * FR) begin
            next_cycle();
            guard++;
            if (frame_tick) ticks++;
        end
        checks++;
        if (ticks != 2) begin
            errors++;
            $display("FAIL enable_tick_timeout: got %0d ticks want 2", ticks);
        end
        for (int j = 0; j < FR + 8; j++) begin
            if (j > 0) next_cycle();
            checks++;
            if ({seg_n, dp_n, an_n, frame_tick} !== {exp_seg, exp_dp, exp_an, exp_tick}) begin
                errors++;
                $display("FAIL enable_model j=%0d: got seg=%b dp=%b an=%b tick=%b want seg=%b dp=%b an=%b tick=%b", j, seg_n, dp_n, an_n, frame_tick, exp_seg, exp_dp, exp_an, exp_tick);
            end
            if (j >= P + 3 && j <= FR + 3) begin
                checks++;
                if (an_n !== 4'hF) begin
                    errors++;
                    $display("FAIL enable_off j=%0d: got an=%b want 1111", j, an_n);
                end
            end
            if (j == FR) begin
                checks++;
                if (frame_tick !== 1'b1) begin
                    errors++;
                    $display("FAIL enable_tick_continues: got tick=%b want 1", frame_tick);
                end
            end
            if (j > FR + 3) begin
                checks++;
                if (an_n !== 4'hE) begin
                    errors++;
                    $display("FAIL enable_resume j=%0d: got an=%b want 1110", j, an_n);
                end
            end
            if (j == P + 2) begin
                @(negedge clk);
                en = 1'b0;
            end
            if (j == FR + 3) begin
                @(negedge clk);
                en = 1'b1;
            end
        end
    endtask

    task automatic test_random();
        int r;
        for (int n = 0; n < 800; n++) begin
            @(negedge clk);
            r = $urandom_range(0, 15);
            case (r)
                0: a1 = 5'($urandom_range(0, 31));
                1: a2 = 5'($urandom_range(0, 31));
                2: a3 = 5'($urandom_range(0, 31));
                3: a4 = 5'($urandom_range(0, 31));
                4: dp = 4'($urandom_range(0, 15));
                5: en = ~en;
                default: ;
            endcase
            next_cycle();
            checks++;
            if ({seg_n, dp_n, an_n, frame_tick} !== {exp_seg, exp_dp, exp_an, exp_tick}) begin
                errors++;
                $display("FAIL random_model n=%0d: got seg=%b dp=%b an=%b tick=%b want seg=%b dp=%b an=%b tick=%b", n, seg_n, dp_n, an_n, frame_tick, exp_seg, exp_dp, exp_an, exp_tick);
            end
        end
    endtask

    task automatic test_async_reset();
        int first;
        first = -1;
        @(negedge clk);
        a1 = 5'd8; a2 = 5'd0; a3 = 5'd15; a4 = 5'd4; dp = 4'hF; en = 1'b1;
        for (int n = 0; n < 45; n++) next_cycle();
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if ({seg_n, dp_n, an_n, frame_tick} !== {7'h7F, 1'b1, 4'hF, 1'b0}) begin
            errors++;
            $display("FAIL async_reset_immediate: got seg=%b dp=%b an=%b tick=%b want 1111111 1 1111 0", seg_n, dp_n, an_n, frame_tick);
        end
        @(negedge clk) rst_n = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            next_cycle();
            checks++;
            if ({seg_n, dp_n, an_n, frame_tick} !== {exp_seg, exp_dp, exp_an, exp_tick}) begin
                errors++;
                $display("FAIL async_reset_model n=%0d: got seg=%b dp=%b an=%b tick=%b want seg=%b dp=%b an=%b tick=%b", n, seg_n, dp_n, an_n, frame_tick, exp_seg, exp_dp, exp_an, exp_tick);
            end
            if (frame_tick && first < 0) first = n;
            if (n <= FR) begin
                checks++;
                if ({seg_n, dp_n} !== {7'h7F, 1'b1}) begin
                    errors++;
                    $display("FAIL async_reset_blank_frame n=%0d: got seg=%b dp=%b", n, seg_n, dp_n);
                end
            end
        end
        checks++;
        if (first != FR + 1) begin
            errors++;
            $display("FAIL async_reset_first_tick: got edge %0d want edge %0d", first, FR + 1);
        end
    endtask

    initial begin
        test_reset();
        test_digits();
        test_codes();
        test_enable();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
